button_event_queue: RTL and testbench



---
 rtl/button_event_queue.sv | 241 ++++++++++++++++++++++++
 tb/tb_button_event_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// -----------------------------------------------------------------------------
// button_event_queue
//
// Collects one-cycle button press pulses, serialises them (lowest index first)
// into a small event FIFO, and exposes the queue to the CPU as a four-register
// memory-mapped peripheral with a level interrupt.
//
// Ports
//   clock   system clock, rising edge
//   reset   asynchronous, active-high; clears all state
//   pulse   one-cycle press pulses, one bit per button
//   addr    register select: 0 STATUS, 1 EVENT, 2 CTRL, 3 COUNTS
//   read    read strobe (one cycle per access)
//   write   write strobe (one cycle per access)
//   wdata   write data
//   rdata   registered read data, held until the next read
//   rvalid  high for one cycle, the cycle after read
//   irq     registered level interrupt
//
// Register map
//   STATUS  [0] empty [1] full [2] overflow (write 1 to clear)
//           [11:4] count  [19:16] pending
//   EVENT   read pops: {1'b1, 29'b0, index} or 0 when empty; writes ignored
//   CTRL    [0] irq_en (r/w)  [1] flush (write-only, reads 0)
//   COUNTS  {cnt3, cnt2, cnt1, cnt0}, one byte lane each; any write clears
// -----------------------------------------------------------------------------
module button_event_queue #(
    parameter int NUM_BUTTONS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] pulse,
    input  logic [1:0]             addr,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   rvalid,
    output logic                   irq
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_COUNTS = 2'd3;

    // Saturating increment for the per-button press counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0] pending;
    logic [1:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [CNT_FW-1:0]      count;
    logic                   overflow;
    logic                   irq_en;
    logic [CNT_W-1:0]       cnt [NUM_BUTTONS];

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   flush;
    logic                   space;
    logic                   grant_valid;
    logic [1:0]             grant_idx;
    logic [NUM_BUTTONS-1:0] grant_onehot;
    logic [NUM_BUTTONS-1:0] granted;
    logic [NUM_BUTTONS-1:0] pending_next;
    logic                   ovf_event;
    logic                   ovf_clear;
    logic                   overflow_next;
    logic                   irq_en_next;
    logic [CNT_FW-1:0]      count_next;
    logic                   cnt_clear;
    logic [CNT_W-1:0]       cnt_next [NUM_BUTTONS];
    logic [31:0]            read_word;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata[31:3];

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = read  && (addr == ADDR_EVENT) && !empty;
    assign flush = write && (addr == ADDR_CTRL) && wdata[1];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign space = !full || pop;

    // Priority pick of the lowest-index pending button.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_valid     = 1'b1;
                grant_idx       = 2'(i);
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // A flush owns the FIFO for its cycle; pending keeps its bits and pushes
    // on the following cycle instead.
    assign push    = grant_valid && space && !flush;
    assign granted = push ? grant_onehot : '0;

    assign pending_next  = (pending | pulse) & ~granted;
    // A press landing on a bit that is still waiting collapses into it.
    assign ovf_event     = |(pulse & pending & ~granted);
    assign ovf_clear     = write && (addr == ADDR_STATUS) && wdata[2];
    assign overflow_next = ovf_event | (overflow & ~ovf_clear);
    assign irq_en_next   = (write && (addr == ADDR_CTRL)) ? wdata[0] : irq_en;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_FW'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_FW'(1);
        end
    end

    assign cnt_clear = write && (addr == ADDR_COUNTS);

    // A pulse coinciding with the clear is counted as the first new press.
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (cnt_clear) begin
                cnt_next[i] = pulse[i] ? CNT_W'(1) : '0;
            end else begin
                cnt_next[i] = sat_inc(cnt[i], pulse[i]);
            end
        end
    end

    // Read mux sees pre-write register values.
    always_comb begin
        read_word = '0;
        case (addr)
            ADDR_STATUS: begin
                read_word[0]                = empty;
                read_word[1]                = full;
                read_word[2]                = overflow;
                read_word[4 +: CNT_FW]      = count;
                read_word[16 +: NUM_BUTTONS] = pending;
            end
            ADDR_EVENT: begin
                if (!empty) begin
                    read_word = {1'b1, 29'b0, mem[rptr]};
                end
            end
            ADDR_CTRL: begin
                read_word[0] = irq_en;
            end
            default: begin
                for (int i = 0; i < NUM_BUTTONS; i++) begin
                    read_word[8*i +: CNT_W] = cnt[i];
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
            irq_en   <= irq_en_next;
            count    <= count_next;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    rptr <= rptr + PTR_W'(1);
                end
            end
            rvalid <= read;
            if (read) begin
                rdata <= read_word;
            end
            irq <= irq_en_next & ((count_next != '0) | overflow_next);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Storage is only observable through count, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// -----------------------------------------------------------------------------
// tb_button_event_queue
//
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the peripheral kept in this file.
// -----------------------------------------------------------------------------
module tb_button_event_queue;

    localparam int DEPTH   = 8;
    localparam int CNT_TOP = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  pulse;
    logic [1:0]  addr;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          q[$];
    logic [3:0]  m_pend;
    bit          m_ovf;
    bit          m_en;
    int          m_cnt[4];
    logic [31:0] m_rdata;
    bit          m_rvalid;
    bit          m_irq;

    button_event_queue #(
        .NUM_BUTTONS(4),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pulse (pulse),
        .addr  (addr),
        .read  (read),
        .write (write),
        .wdata (wdata),
        .rdata (rdata),
        .rvalid(rvalid),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend   = '0;
        m_ovf    = 0;
        m_en     = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_rdata  = '0;
        m_rvalid = 0;
        m_irq    = 0;
    endtask

    function automatic logic [31:0] read_value(input logic [1:0] a);
        logic [31:0] v = '0;
        case (a)
            2'd0: begin
                v[0]     = (q.size() == 0);
                v[1]     = (q.size() == DEPTH);
                v[2]     = m_ovf;
                v[11:4]  = 8'(q.size());
                v[19:16] = m_pend;
            end
            2'd1: if (q.size() > 0) v = 32'h8000_0000 | 32'(q[0]);
            2'd2: v[0] = m_en;
            default: for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(m_cnt[i]);
        endcase
        return v;
    endfunction

    task automatic model_step(input logic [3:0] p, input logic [1:0] a, input logic r,
                              input logic w, input logic [31:0] wd);
        int gi;
        bit pop, flush, push, ovf_evt;
        if (r) m_rdata = read_value(a);
        m_rvalid = r;
        pop   = r && (a == 2'd1) && (q.size() > 0);
        flush = w && (a == 2'd2) && wd[1];
        gi = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) gi = i;
        push = (gi >= 0) && !flush && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        if (push) q.push_back(gi);
        ovf_evt = 0;
        for (int i = 0; i < 4; i++) begin
            if (push && (i == gi)) begin
                m_pend[i] = 1'b0;
            end else if (p[i]) begin
                if (m_pend[i]) ovf_evt = 1;
                m_pend[i] = 1'b1;
            end
        end
        m_ovf = ovf_evt || (m_ovf && !(w && (a == 2'd0) && wd[2]));
        if (w && (a == 2'd2)) m_en = wd[0];
        for (int i = 0; i < 4; i++) begin
            if (w && (a == 2'd3)) m_cnt[i] = p[i] ? 1 : 0;
            else if (p[i] && (m_cnt[i] < CNT_TOP)) m_cnt[i]++;
        end
        m_irq = m_en && ((q.size() != 0) || m_ovf);
    endtask

    // One bus/pulse cycle: drive, advance the model, clock, compare outputs.
    task automatic do_cycle(input logic [3:0] p, input logic [1:0] a, input logic r,
                            input logic w, input logic [31:0] wd);
        pulse = p; addr = a; read = r; write = w; wdata = wd;
        model_step(p, a, r, w, wd);
        @(posedge clock);
        #1;
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rdata", rdata, m_rdata);
        pulse = '0; read = 1'b0; write = 1'b0; wdata = '0;
    endtask

    initial begin
        logic [3:0]  rp;
        logic [1:0]  ra;
        logic [31:0] rw;
        logic        rr, rwr;

        reset = 1'b1;
        pulse = '0; addr = '0; read = 1'b0; write = 1'b0; wdata = '0;
        model_reset();
        #12;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // STATUS after reset
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_after_reset", rdata, 32'h0000_0001);
        chk("rvalid_after_read", 32'(rvalid), 32'h1);
        do_cycle(4'b0000, 2'd0, 1'b0, 1'b0, 32'h0);
        chk("rvalid_one_cycle", 32'(rvalid), 32'h0);
        chk("rdata_holds", rdata, 32'h0000_0001);

        // Single press on button 2
        do_cycle(4'b0100, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("event_btn2", rdata, 32'h8000_0002);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("event_empty", rdata, 32'h0000_0000);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_empty_again", rdata, 32'h0000_0001);

        // Coincident presses on 0, 1, 3 after clearing counters
        do_cycle(4'b0000, 2'd3, 1'b0, 1'b1, 32'h0);
        do_cycle(4'b1011, 2'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_three", rdata, 32'h0000_0030);
        do_cycle(4'b0000, 2'd3, 1'b1, 1'b0, 32'h0);
        chk("counts_three", rdata, 32'h0100_0101);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("order_0", rdata, 32'h8000_0000);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("order_1", rdata, 32'h8000_0001);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("order_3", rdata, 32'h8000_0003);

        // Fill to full with irq enabled
        do_cycle(4'b0000, 2'd2, 1'b0, 1'b1, 32'h1);
        do_cycle(4'b0000, 2'd2, 1'b1, 1'b0, 32'h0);
        chk("ctrl_readback", rdata, 32'h0000_0001);
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b0010, 2'd0, 1'b0, 1'b0, 32'h0);
            do_cycle(4'b0000, 2'd0, 1'b0, 1'b0, 32'h0);
        end
        chk("irq_full", 32'(irq), 32'h1);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_full", rdata, 32'h0000_0082);
        do_cycle(4'b0010, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_full_pending", rdata, 32'h0002_0082);
        do_cycle(4'b0010, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_overflow", rdata, 32'h0002_0086);
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("pop_when_full", rdata, 32'h8000_0001);
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_pop_push", rdata, 32'h0000_0086);
        do_cycle(4'b0000, 2'd0, 1'b0, 1'b1, 32'h4);
        do_cycle(4'b0000, 2'd2, 1'b0, 1'b1, 32'h3);
        do_cycle(4'b0000, 2'd2, 1'b1, 1'b0, 32'h0);
        chk("flush_ctrl_reads", rdata, 32'h0000_0001);
        chk("irq_after_flush", 32'(irq), 32'h0);

        // Counter saturation and clear
        for (int i = 0; i < 300; i++) do_cycle(4'b0001, 2'd0, 1'b0, 1'b0, 32'h0);
        do_cycle(4'b0000, 2'd3, 1'b1, 1'b0, 32'h0);
        chk("cnt0_saturated", {24'h0, rdata[7:0]}, 32'h0000_00FF);
        do_cycle(4'b0000, 2'd3, 1'b0, 1'b1, 32'h0);
        do_cycle(4'b0000, 2'd3, 1'b1, 1'b0, 32'h0);
        chk("counts_cleared", rdata, 32'h0);

        // Asynchronous reset with five entries queued
        do_cycle(4'b0000, 2'd0, 1'b0, 1'b1, 32'h4);
        do_cycle(4'b0000, 2'd2, 1'b0, 1'b1, 32'h3);
        for (int i = 0; i < 5; i++) begin
            do_cycle(4'(1 << (i % 4)), 2'd0, 1'b0, 1'b0, 32'h0);
            do_cycle(4'b0000, 2'd0, 1'b0, 1'b0, 32'h0);
        end
        do_cycle(4'b0000, 2'd1, 1'b1, 1'b0, 32'h0);
        chk("pre_reset_rvalid", 32'(rvalid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rdata", rdata, 32'h0);
        chk("async_rvalid", 32'(rvalid), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        do_cycle(4'b0000, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("status_after_async", rdata, 32'h0000_0001);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            rp  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            ra  = 2'($urandom);
            rr  = ($urandom_range(0, 2) == 0);
            rwr = ($urandom_range(0, 5) == 0);
            rw  = $urandom;
            do_cycle(rp, ra, rr, rwr, rw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
